// File: rtl/past_sum_scheduler.sv
// past_sum_scheduler: sums each accepted sample with earlier samples taken at
// power-of-two distances (1, 2, 4, ... 2^(N-2)) from a 2^N-entry history ring.
// One shared adder folds in one tap per cycle, so a result appears N cycles
// after acceptance and a new sample can be taken every N+1 cycles.
module past_sum_scheduler #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    localparam int           DEPTH    = 1 << N;
    localparam logic [3:0]   LAST_TAP = 4'(N - 1);
    localparam logic [N-1:0] PTR_ONE  = N'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] hist [DEPTH];
    logic [N-1:0]  wp;
    logic [DW-1:0] acc;
    logic [3:0]    tap;

    logic [N-1:0]  tap_off;
    logic [N-1:0]  rd_idx;
    logic [DW-1:0] tap_val;

    // Modulo-2^DW addition: the carry out of the top bit is simply dropped.
    function automatic logic [DW-1:0] add_wrap(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        return a + b;
    endfunction

    // Tap i reaches back 2^(i-1) samples; the N-bit subtraction wraps the ring.
    always_comb begin
        tap_off = PTR_ONE << (tap - 4'd1);
        rd_idx  = wp - tap_off;
        tap_val = hist[rd_idx];
    end

    // Only IDLE takes samples, and a clear request in IDLE blocks acceptance.
    // Reset gating keeps the handshake low while the block is held in reset.
    always_comb begin
        in_ready = (state == IDLE) && !clr && !rst;
        out_data = acc;
    end

    // Control FSM with history ring, accumulator and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wp        <= '0;
            acc       <= '0;
            tap       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        // Clear wins over a pending sample; history restarts empty.
                        wp <= '0;
                        for (int k = 0; k < DEPTH; k++) begin
                            hist[k] <= '0;
                        end
                    end else if (in_valid) begin
                        hist[wp] <= in_data;
                        acc      <= in_data;
                        tap      <= 4'd1;
                        busy     <= 1'b1;
                        if (N > 1) begin
                            state <= ACCUM;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    acc <= add_wrap(acc, tap_val);
                    tap <= tap + 4'd1;
                    if (tap == LAST_TAP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // The pointer only advances once the result has been taken,
                    // so a stalled consumer never shifts the tap positions.
                    if (out_ready) begin
                        wp        <= wp + PTR_ONE;
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_past_sum_scheduler.sv
// Self-checking bench for past_sum_scheduler: a queue-based history model
// predicts each sum, predictions go into a scoreboard queue, and a monitor
// compares every output handshake against it.
`timescale 1ns/1ps
module tb_past_sum_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          clr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    logic [DW-1:0] last_out = '0;
    int exp_q[$];
    int hist_q[$];
    int obs_q[$];
    int exp32[5] = '{1, 3, 6, 9, 13};
    bit rand_rdy = 1'b0;

    past_sum_scheduler #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .clr      (clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Sum of the new sample and the samples 1, 2, 4, ... back in accepted order.
    function automatic int ref_sum(input int d);
        int s;
        s = d;
        for (int i = 1; i < N; i++) begin
            int off;
            off = 1 << (i - 1);
            if (hist_q.size() >= off) s += hist_q[hist_q.size() - off];
        end
        return s % (1 << DW);
    endfunction

    task automatic model_accept(input int d);
        exp_q.push_back(ref_sum(d));
        hist_q.push_back(d);
        if (hist_q.size() > (1 << N)) void'(hist_q.pop_front());
    endtask

    task automatic model_clear();
        hist_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input bit check_lat);
        int w;
        w = 0;
        in_data  = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            step();
        end
        acc_cyc = cyc;
        model_accept(d);
        step();
        in_valid = 1'b0;
        if (check_lat) begin
            for (int k = 1; k <= N; k++) begin
                if (k > 1) step();
                chk("lat_out_valid", out_valid, (k == N));
                chk("lat_busy", busy, 1);
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            step();
            w++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 300) begin
            step();
            w++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic do_clr();
        wait_idle();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        chk("clr_in_ready", in_ready, 0);
        model_clear();
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    // Monitor: one scoreboard pop per output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                chk("ready_valid_exclusive", in_ready && out_valid, 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %0d, want no output", out_data);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e);
                        last_out = out_data;
                        obs_q.push_back(int'(out_data));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        logic [DW-1:0] held;
        int w;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clr       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Single sample: latency N, result equals the sample.
        send(8'd5, 1'b1);
        step();
        chk("single_busy_after", busy, 0);
        chk("single_out", last_out, 5);

        // Back-to-back stream 1..5 from an empty history.
        do_clr();
        obs_q.delete();
        prev = 0;
        for (int v = 1; v <= 5; v++) begin
            send(DW'(v), 1'b0);
            if (v > 1) chk("initiation_interval", acc_cyc - prev, N + 1);
            prev = acc_cyc;
        end
        drain();
        chk("stream_count", obs_q.size(), 5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) chk("stream_value", obs_q[i], exp32[i]);

        // Wrap-around of the adder.
        do_clr();
        send(8'd200, 1'b0);
        send(8'd200, 1'b0);
        drain();
        chk("wrap_sum", last_out, 144);

        // Consumer stall in DONE with a second sample waiting.
        out_ready = 1'b0;
        send(8'd30, 1'b0);
        w = 0;
        while (!out_valid && w < 50) begin
            step();
            w++;
        end
        chk("stall_reach_done", out_valid, 1);
        held = out_data;
        if (exp_q.size() != 0) chk("stall_value", held, exp_q[0]);
        in_data  = 8'd77;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, held);
            chk("stall_in_ready", in_ready, 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(8'd77, 1'b0);
        drain();

        // Clear with a competing sample, then a fresh history.
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        drain();
        do_clr();
        send(8'd7, 1'b0);
        drain();
        chk("after_clr_out", last_out, 7);

        // Reset in the middle of accumulating the second sample.
        send(8'd10, 1'b0);
        drain();
        send(8'd20, 1'b0);
        chk("mid_accum_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        model_clear();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("release_in_ready", in_ready, 1);
        send(8'd5, 1'b0);
        drain();
        chk("after_abort_out", last_out, 5);

        // Randomised traffic with random back-pressure and occasional clears.
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) do_clr();
            send(DW'($urandom_range(0, 255)), 1'b0);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
